// File: rtl/transmisor_i2s.sv
// Mono I2S transmitter: one-deep sample buffer feeding a frame serialiser.
// BCLK is derived from the system clock; both slots carry the same sample.
module transmisor_i2s #(
    parameter int ANCHO = 20,
    parameter int SLOT  = 32,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] dato_in,
    input  logic             valido_in,
    output logic             listo_out,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             subdesbordamiento
);

    localparam int BW = $clog2(2 * SLOT);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] ULT_BIT = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SLOT_C  = BW'(SLOT);
    localparam logic [DW-1:0] ULT_DIV = DW'(DIV - 1);

    typedef enum logic {
        ESPERA,
        TRANSMITE
    } estado_t;

    estado_t          estado;
    logic [ANCHO-1:0] buffer_q;
    logic [ANCHO-1:0] trama;
    logic             lleno;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    logic [BW-1:0]    nxt_bit;
    logic [BW-1:0]    pos;
    logic             bit_sig;
    logic             escribe;
    logic             fin_div;
    logic             bajada;
    logic             vuelta;
    logic             carga;

    assign listo_out = !lleno;
    assign escribe   = valido_in && !lleno;
    assign fin_div   = (div_cnt == ULT_DIV);
    assign bajada    = (estado == TRANSMITE) && fin_div && bclk;
    assign vuelta    = bajada && (bit_cnt == ULT_BIT);
    assign carga     = lleno && ((estado == ESPERA) || vuelta);

    // Slot position of the bit that becomes current after the next fall
    always_comb begin
        nxt_bit = (bit_cnt == ULT_BIT) ? '0 : bit_cnt + BW'(1);
        pos     = (nxt_bit >= SLOT_C) ? nxt_bit - SLOT_C : nxt_bit;
        bit_sig = 1'b0;
        for (int i = 0; i < ANCHO; i++) begin
            if (int'(pos) == ANCHO - i) begin
                bit_sig = trama[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer_q <= '0;
            lleno    <= 1'b0;
        end else if (escribe) begin
            buffer_q <= dato_in;
            lleno    <= 1'b1;
        end else if (carga) begin
            lleno    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado            <= ESPERA;
            trama             <= '0;
            bit_cnt           <= '0;
            div_cnt           <= '0;
            bclk              <= 1'b0;
            lrclk             <= 1'b0;
            sdata             <= 1'b0;
            subdesbordamiento <= 1'b0;
        end else begin
            subdesbordamiento <= 1'b0;
            unique case (estado)
                ESPERA: begin
                    bclk  <= 1'b0;
                    lrclk <= 1'b0;
                    sdata <= 1'b0;
                    if (lleno) begin
                        trama   <= buffer_q;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        estado  <= TRANSMITE;
                    end
                end
                TRANSMITE: begin
                    if (fin_div) begin
                        div_cnt <= '0;
                        bclk    <= !bclk;
                        if (bclk) begin
                            bit_cnt <= nxt_bit;
                            lrclk   <= (nxt_bit >= SLOT_C);
                            sdata   <= bit_sig;
                            if (vuelta) begin
                                if (lleno) begin
                                    trama <= buffer_q;
                                end else begin
                                    subdesbordamiento <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
